// File: rtl/spike_rate_encoder.sv
// Rate-codes one intensity sample into a WINDOW-cycle spike train; first spike slot is 1 cycle after accept.
// in_ready is low during a window except its last cycle, which allows back-to-back samples; flush forces it low.
module spike_rate_encoder #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             intensity,
  input  logic                         flush,
  output logic                         S,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WINDOW+1)-1:0]  spike_count
);

  localparam int SW = $clog2(WINDOW);
  localparam int CW = $clog2(WINDOW + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] lat, lat_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [SW-1:0]    step, step_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             s_q, s_nx;
  logic             done_q, done_nx;
  logic             last;
  logic             accept;
  logic [WIDTH:0]   sum;

  assign last     = (state == RUN) && (step == SW'(WINDOW - 1));
  assign in_ready = !flush && ((state == IDLE) || last);
  assign accept   = in_valid && in_ready;
  assign sum      = {1'b0, acc} + {1'b0, lat};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    lat_nx   = lat;
    acc_nx   = acc;
    step_nx  = step;
    cnt_nx   = cnt;
    s_nx     = 1'b0;
    done_nx  = 1'b0;
    if (flush) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (accept) begin
      // Phase starts at zero; the first step (0 + I) can never carry, so it is
      // folded into the accept edge and S for cycle 1 is simply 0.
      state_nx = RUN;
      lat_nx   = intensity;
      acc_nx   = intensity;
      step_nx  = '0;
      cnt_nx   = '0;
    end else if (last) begin
      state_nx = IDLE;
    end else if (state == RUN) begin
      s_nx    = sum[WIDTH];
      acc_nx  = sum[WIDTH-1:0];
      step_nx = step + SW'(1);
      cnt_nx  = cnt + CW'(sum[WIDTH]);
      done_nx = (step == SW'(WINDOW - 2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat    <= '0;
      acc    <= '0;
      step   <= '0;
      cnt    <= '0;
      s_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      lat    <= lat_nx;
      acc    <= acc_nx;
      step   <= step_nx;
      cnt    <= cnt_nx;
      s_q    <= s_nx;
      done_q <= done_nx;
    end
  end

  assign S           = s_q;
  assign busy        = (state == RUN);
  assign done        = done_q;
  assign spike_count = cnt;

endmodule
